// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 -> 16-bit unsigned multiplier built around one shared 4x4 array
// multiplier, stepped over four nibble-pair cycles with shift-accumulate.

module multiplier_4_x_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] sum;

    // Array form: one AND-gated row of a per bit of b, weighted by that bit's position.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum = sum + ({4'b0000, a & {4{b[i]}}} << i);
        end
    end

    assign p = sum;

endmodule

module mult8_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  step;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [15:0] acc;
    logic [15:0] acc_nx;
    logic [15:0] product_r;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  pp;
    logic [15:0] pp_sh;

    multiplier_4_x_4 u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (pp)
    );

    // Nibble schedule: low*low, high*low, low*high, high*high.
    always_comb begin
        mul_a = a_r[3:0];
        mul_b = b_r[3:0];
        pp_sh = {8'h00, pp};
        case (step)
            2'd0: begin
                mul_a = a_r[3:0];
                mul_b = b_r[3:0];
                pp_sh = {8'h00, pp};
            end
            2'd1: begin
                mul_a = a_r[7:4];
                mul_b = b_r[3:0];
                pp_sh = {4'h0, pp, 4'h0};
            end
            2'd2: begin
                mul_a = a_r[3:0];
                mul_b = b_r[7:4];
                pp_sh = {4'h0, pp, 4'h0};
            end
            default: begin
                mul_a = a_r[7:4];
                mul_b = b_r[7:4];
                pp_sh = {pp, 8'h00};
            end
        endcase
    end

    assign acc_nx = acc + pp_sh;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = MUL;
            MUL:     if (step == 2'd3) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            product_r <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r  <= a;
                        b_r  <= b;
                        acc  <= '0;
                        step <= '0;
                    end
                end
                MUL: begin
                    acc  <= acc_nx;
                    step <= step + 2'd1;
                    if (step == 2'd3) product_r <= acc_nx;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state == MUL) || (state == DONE);
    assign done    = (state == DONE);
    assign product = product_r;

endmodule
